// File: rtl/mini_src_control_seq_if.sv
// Datapath control interface between the Mini SRC sequencer and the datapath.
// master: sequencer side, drives every control and reads IR opcode plus CON_FF.
// slave : datapath side, the mirror image.
// Signal names match the datapath port names so the two ends connect 1:1.
interface mini_src_control_seq_if;
  // Register enables
  logic       incPC;
  logic       e_PC;
  logic       e_IR;
  logic       e_Y;
  logic       e_Z;
  logic       e_MDR;
  logic       e_MAR;
  logic       e_CON_FF;
  // Memory controls
  logic       ram_read;
  logic       ram_write;
  logic       MDR_read;
  // ALU and bus
  logic [3:0] ALU_op;
  logic [4:0] BusDataSelect;
  // Select/encode and operand mux
  logic       Gra;
  logic       Grb;
  logic       Grc;
  logic       e_Rin;
  logic       e_Rout;
  logic       BAout;
  logic       imm_sel;
  // Status back from the datapath
  logic [4:0] ir_op;
  logic       con;

  modport master (
    output incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF,
    output ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
    output Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
    input  ir_op, con
  );

  modport slave (
    input  incPC, e_PC, e_IR, e_Y, e_Z, e_MDR, e_MAR, e_CON_FF,
    input  ram_read, ram_write, MDR_read, ALU_op, BusDataSelect,
    input  Gra, Grb, Grc, e_Rin, e_Rout, BAout, imm_sel,
    output ir_op, con
  );
endinterface

// File: rtl/mini_src_control_seq.sv
// Hardwired Moore control sequencer for the Mini SRC datapath.
// Fetches an instruction, decodes IR[31:27] and steps LD/LDI/ST/ADDI/BR/JR/JAL/NOP/HALT
// through T-states. Every control output is a pure decode of the state register.
// Ports:
//   clock    - system clock, all state changes on posedge
//   clear_n  - asynchronous active-low reset, returns to IDLE with all outputs 0
//   go       - start pulse, only honoured in IDLE
//   dp       - datapath control interface (master end)
//   run      - high from go until HALT
//   halted   - high in the HALT state
//   illegal  - only with ILLEGAL_TRAP_EN: set when an undecoded opcode traps to HALT
// Configuration macro: ILLEGAL_TRAP_EN (undefined: undecoded opcodes behave as NOP).
// RAM_WAIT must be 1..3 (cycles a memory read/write is held before data valid/commit).
module mini_src_control_seq #(
  parameter int unsigned RAM_WAIT = 1,
  parameter logic [3:0]  ALU_ADD  = 4'b0011
) (
  input  logic                          clock,
  input  logic                          clear_n,
  input  logic                          go,
  mini_src_control_seq_if.master        dp,
`ifdef ILLEGAL_TRAP_EN
  output logic                          illegal,
`endif
  output logic                          run,
  output logic                          halted
);

  localparam logic [4:0] BusGpr   = 5'b00000;
  localparam logic [4:0] BusZlo   = 5'b10011;
  localparam logic [4:0] BusPc    = 5'b10100;
  localparam logic [4:0] BusMdr   = 5'b10101;
  localparam logic [1:0] WaitLoad = 2'(RAM_WAIT - 1);

  typedef enum logic [4:0] {
    StIdle, StF0, StF1, StF2, StF3, StDec,
    StA1, StA1Add, StA2, StA3,
    StL3, StL4, StL5, StL6,
    StS3, StS4, StS5,
    StJ1, StK1, StK2,
    StB1, StB2, StB3, StB4Take, StB4Skip,
    StHalt
  } state_e;

  // Which tail follows the shared A1/A2 effective-address/immediate-add steps
  typedef enum logic [1:0] {KindAlu, KindLoad, KindStore} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [1:0]  wait_q, wait_d;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_q, illegal_d;
`endif

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= StIdle;
      kind_q    <= KindAlu;
      wait_q    <= 2'd0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      wait_q    <= wait_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    kind_d    = kind_q;
    wait_d    = wait_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      StIdle: if (go) state_d = StF0;
      StF0: begin
        state_d = StF1;
        wait_d  = WaitLoad;
      end
      StF1: begin
        if (wait_q == 2'd0) state_d = StF2;
        else                wait_d  = wait_q - 2'd1;
      end
      StF2: state_d = StF3;
      StF3: state_d = StDec;
      StDec: begin
        case (dp.ir_op)
          5'b01000: begin state_d = StA1;    kind_d = KindAlu;   end
          5'b00000: begin state_d = StA1;    kind_d = KindLoad;  end
          5'b00010: begin state_d = StA1;    kind_d = KindStore; end
          5'b01100: begin state_d = StA1Add; kind_d = KindAlu;   end
          5'b10010: state_d = StB1;
          5'b10011: state_d = StJ1;
          5'b10100: state_d = StK1;
          5'b11010: state_d = StF0;
          5'b11011: state_d = StHalt;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = StHalt;
            illegal_d = 1'b1;
`else
            state_d   = StF0;
`endif
          end
        endcase
      end
      StA1, StA1Add: state_d = StA2;
      StA2: begin
        case (kind_q)
          KindLoad:  state_d = StL3;
          KindStore: state_d = StS3;
          default:   state_d = StA3;
        endcase
      end
      StA3: state_d = StF0;
      StL3: begin
        state_d = StL4;
        wait_d  = WaitLoad;
      end
      StL4: begin
        if (wait_q == 2'd0) state_d = StL5;
        else                wait_d  = wait_q - 2'd1;
      end
      StL5: state_d = StL6;
      StL6: state_d = StF0;
      StS3: state_d = StS4;
      StS4: begin
        state_d = StS5;
        wait_d  = WaitLoad;
      end
      StS5: begin
        if (wait_q == 2'd0) state_d = StF0;
        else                wait_d  = wait_q - 2'd1;
      end
      StJ1: state_d = StF0;
      StK1: state_d = StK2;
      StK2: state_d = StF0;
      StB1: state_d = StB2;
      StB2: state_d = StB3;
      // CON_FF was loaded at the end of B1 and is stable from then on, so the
      // taken/not-taken choice is folded into the state to keep B4 a pure Moore decode.
      StB3: state_d = dp.con ? StB4Take : StB4Skip;
      StB4Take, StB4Skip: state_d = StF0;
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin : out_decode
    dp.incPC         = 1'b0;
    dp.e_PC          = 1'b0;
    dp.e_IR          = 1'b0;
    dp.e_Y           = 1'b0;
    dp.e_Z           = 1'b0;
    dp.e_MDR         = 1'b0;
    dp.e_MAR         = 1'b0;
    dp.e_CON_FF      = 1'b0;
    dp.ram_read      = 1'b0;
    dp.ram_write     = 1'b0;
    dp.MDR_read      = 1'b0;
    dp.ALU_op        = 4'b0000;
    dp.BusDataSelect = BusGpr;
    dp.Gra           = 1'b0;
    dp.Grb           = 1'b0;
    dp.Grc           = 1'b0;
    dp.e_Rin         = 1'b0;
    dp.e_Rout        = 1'b0;
    dp.BAout         = 1'b0;
    dp.imm_sel       = 1'b0;
    run              = (state_q != StIdle) && (state_q != StHalt);
    halted           = (state_q == StHalt);
    case (state_q)
      StF0:     begin dp.BusDataSelect = BusPc;  dp.e_MAR = 1'b1; dp.incPC = 1'b1; end
      StF1, StL4: dp.ram_read = 1'b1;
      StF2, StL5: begin dp.MDR_read = 1'b1; dp.e_MDR = 1'b1; end
      StF3:     begin dp.BusDataSelect = BusMdr; dp.e_IR = 1'b1; end
      // BAout makes R0 read as zero for address/immediate forms; ADDI uses the real R0
      StA1:     begin dp.Grb = 1'b1; dp.e_Rout = 1'b1; dp.e_Y = 1'b1; dp.BAout = 1'b1; end
      StA1Add:  begin dp.Grb = 1'b1; dp.e_Rout = 1'b1; dp.e_Y = 1'b1; end
      StA2, StB3: begin dp.imm_sel = 1'b1; dp.ALU_op = ALU_ADD; dp.e_Z = 1'b1; end
      StA3:     begin dp.BusDataSelect = BusZlo; dp.Gra = 1'b1; dp.e_Rin = 1'b1; end
      StL3, StS3: begin dp.BusDataSelect = BusZlo; dp.e_MAR = 1'b1; end
      StL6:     begin dp.BusDataSelect = BusMdr; dp.Gra = 1'b1; dp.e_Rin = 1'b1; end
      StS4:     begin dp.Gra = 1'b1; dp.e_Rout = 1'b1; dp.e_MDR = 1'b1; end
      StS5:     dp.ram_write = 1'b1;
      StJ1, StK2: begin dp.Gra = 1'b1; dp.e_Rout = 1'b1; dp.e_PC = 1'b1; end
      StK1:     begin dp.BusDataSelect = BusPc;  dp.Grb = 1'b1; dp.e_Rin = 1'b1; end
      StB1:     begin dp.Gra = 1'b1; dp.e_Rout = 1'b1; dp.e_CON_FF = 1'b1; end
      StB2:     begin dp.BusDataSelect = BusPc;  dp.e_Y = 1'b1; end
      StB4Take: begin dp.BusDataSelect = BusZlo; dp.e_PC = 1'b1; end
      default: ;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`endif

endmodule

// File: tb/tb_mini_src_control_seq.sv
// Bench for mini_src_control_seq: a small behavioural Mini SRC datapath and RAM are
// driven by the sequencer and a short program is run; register, memory and PC results
// are compared with hand-computed values. Honours ILLEGAL_TRAP_EN.
module tb_mini_src_control_seq;

  logic clock = 1'b0;
  logic clear_n;
  logic go;
  logic run;
  logic halted;
`ifdef ILLEGAL_TRAP_EN
  logic illegal;
`endif

  mini_src_control_seq_if dp ();

  mini_src_control_seq dut (
    .clock   (clock),
    .clear_n (clear_n),
    .go      (go),
    .dp      (dp),
`ifdef ILLEGAL_TRAP_EN
    .illegal (illegal),
`endif
    .run     (run),
    .halted  (halted)
  );

  always #5 clock = ~clock;

  // Initial images, written only by the stimulus; the model loads them while in reset
  logic [31:0] init_r   [16];
  logic [31:0] init_mem [256];
  logic [31:0] init_pc;

  // Datapath model state
  logic [31:0] r   [16];
  logic [31:0] mem [256];
  logic [31:0] pc, mar, mdr, ir, y, z, memrd;
  logic        con_ff;

  logic [3:0]  sel_idx;
  logic [31:0] gpr_out, bus, alu_b, c_sext;
  logic [26:0] ctl;

  always_comb begin
    sel_idx = dp.Gra ? ir[26:23] : dp.Grb ? ir[22:19] : dp.Grc ? ir[18:15] : 4'd0;
    gpr_out = (dp.BAout && sel_idx == 4'd0) ? 32'd0 : r[sel_idx];
    case (dp.BusDataSelect)
      5'b10011: bus = z;
      5'b10100: bus = pc;
      5'b10101: bus = mdr;
      default:  bus = gpr_out;
    endcase
    c_sext = {{13{ir[18]}}, ir[18:0]};
    alu_b  = dp.imm_sel ? c_sext : bus;
    ctl = {dp.incPC, dp.e_PC, dp.e_IR, dp.e_Y, dp.e_Z, dp.e_MDR, dp.e_MAR, dp.e_CON_FF,
           dp.ram_read, dp.ram_write, dp.MDR_read, dp.ALU_op, dp.BusDataSelect,
           dp.Gra, dp.Grb, dp.Grc, dp.e_Rin, dp.e_Rout, dp.BAout, dp.imm_sel};
  end

  assign dp.ir_op = ir[31:27];
  assign dp.con   = con_ff;

  always @(posedge clock) begin
    if (!clear_n) begin
      for (int i = 0; i < 16; i++)  r[i]   <= init_r[i];
      for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
      pc <= init_pc; mar <= '0; mdr <= '0; ir <= '0; y <= '0; z <= '0; memrd <= '0;
      con_ff <= 1'b0;
    end else begin
      if (dp.incPC)     pc <= pc + 32'd1;
      if (dp.e_PC)      pc <= bus;
      if (dp.e_MAR)     mar <= bus;
      if (dp.ram_read)  memrd <= mem[mar[7:0]];
      if (dp.e_MDR)     mdr <= dp.MDR_read ? memrd : bus;
      if (dp.ram_write) mem[mar[7:0]] <= mdr;
      if (dp.e_IR)      ir <= bus;
      if (dp.e_Y)       y <= bus;
      if (dp.e_Z)       z <= (dp.ALU_op == 4'b0011) ? y + alu_b : 32'hDEAD_BEEF;
      if (dp.e_Rin)     r[sel_idx] <= bus;
      if (dp.e_CON_FF) begin
        case (ir[20:19])
          2'b00: con_ff <= (bus == 32'd0);
          2'b01: con_ff <= (bus != 32'd0);
          2'b10: con_ff <= !bus[31];
          default: con_ff <= bus[31];
        endcase
      end
    end
  end

  // Activity monitor: fetch log, exclusivity and e_PC counters
  int          cyc, n_fetch, n_epc, n_excl;
  logic [31:0] fetch_addr [64];
  int          fetch_cyc  [64];

  initial begin
    cyc = 0; n_fetch = 0; n_epc = 0; n_excl = 0;
  end

  always @(negedge clock) begin
    if (clear_n) begin
      cyc = cyc + 1;
      if (dp.incPC && n_fetch < 64) begin
        fetch_addr[n_fetch] = pc;
        fetch_cyc[n_fetch]  = cyc;
        n_fetch = n_fetch + 1;
      end
      if (dp.e_PC) n_epc = n_epc + 1;
      if (dp.e_Rin && dp.e_Rout) n_excl = n_excl + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_go();
    @(negedge clock) go = 1'b1;
    @(negedge clock) go = 1'b0;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && !halted; i++) @(negedge clock);
    check_eq("halt_reached", 32'(halted), 32'd1);
  endtask

  int base, epc0;

  initial begin
    for (int i = 0; i < 16; i++)  init_r[i] = '0;
    for (int i = 0; i < 256; i++) init_mem[i] = '0;
    init_pc      = 32'd0;
    init_r[5]    = 32'h20;        // JAL target
    init_r[10]   = 32'd7;         // JR target
    init_mem[0]    = 32'h4100_0078; // LDI  R2,0x78
    init_mem[1]    = 32'h0310_0063; // LD   R6,0x63(R2)
    init_mem[2]    = 32'h1300_0010; // ST   R6,0x10(R0)
    init_mem[3]    = 32'hA2C0_0000; // JAL  R5,R8
    init_mem[32'h20] = 32'h6490_0005; // ADDI R9,R2,5
    init_mem[32'h21] = 32'h9D00_0000; // JR   R10
    init_mem[7]    = 32'h9180_0005; // BRZR R3,5
    init_mem[8]    = 32'hD800_0000; // HALT (not-taken landing)
    init_mem[32'hD]  = 32'hD000_0000; // NOP
    init_mem[32'hE]  = 32'hF800_0000; // undefined 11111
    init_mem[32'hF]  = 32'hD800_0000; // HALT
    init_mem[32'hDB] = 32'h0000_1234;

    // Reset held with go asserted
    clear_n = 1'b0;
    go      = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("reset_ctl", 32'(ctl), 32'd0);
    check_eq("reset_run", 32'(run), 32'd0);
    check_eq("reset_halted", 32'(halted), 32'd0);
`ifdef ILLEGAL_TRAP_EN
    check_eq("reset_illegal", 32'(illegal), 32'd0);
`endif
    clear_n = 1'b1;
    go      = 1'b0;
    @(negedge clock);
    check_eq("idle_run", 32'(run), 32'd0);

    // go -> F0
    @(negedge clock) go = 1'b1;
    @(negedge clock);
    check_eq("f0_bus", 32'(dp.BusDataSelect), 32'h14);
    check_eq("f0_e_mar", 32'(dp.e_MAR), 32'd1);
    check_eq("f0_incpc", 32'(dp.incPC), 32'd1);
    check_eq("f0_run", 32'(run), 32'd1);
    go = 1'b0;
    @(negedge clock);
    check_eq("f1_ram_read", 32'(dp.ram_read), 32'd1);
    @(negedge clock);
    check_eq("f2_mdr_read", 32'(dp.MDR_read & dp.e_MDR), 32'd1);

    wait_halted(300);
    check_eq("ldi_r2", r[2], 32'h78);
    check_eq("ldi_cycles", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd8);
    check_eq("ld_r6", r[6], 32'h1234);
    check_eq("st_mem10", mem[32'h10], 32'h1234);
    check_eq("jal_r8", r[8], 32'd4);
    check_eq("jal_fetch", fetch_addr[4], 32'h20);
    check_eq("addi_r9", r[9], 32'h7D);
    check_eq("jr_fetch", fetch_addr[6], 32'd7);
    check_eq("br_taken_fetch", fetch_addr[7], 32'hD);
`ifdef ILLEGAL_TRAP_EN
    check_eq("trap_illegal", 32'(illegal), 32'd1);
    check_eq("trap_fetches", 32'(n_fetch), 32'd9);
`else
    check_eq("nop_fetches", 32'(n_fetch), 32'd10);
    check_eq("halt_fetch", fetch_addr[9], 32'hF);
`endif
    check_eq("rin_rout_excl", 32'(n_excl), 32'd0);

    // go in HALT is ignored
    base = n_fetch;
    pulse_go();
    pulse_go();
    @(negedge clock);
    check_eq("halt_halted", 32'(halted), 32'd1);
    check_eq("halt_run", 32'(run), 32'd0);
    check_eq("halt_ctl", 32'(ctl), 32'd0);
    check_eq("halt_no_fetch", 32'(n_fetch - base), 32'd0);

    // Branch not taken: R3=1, start at PC=7
    init_r[3] = 32'd1;
    init_pc   = 32'd7;
    clear_n   = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst2_halted", 32'(halted), 32'd0);
    clear_n = 1'b1;
    base    = n_fetch;
    epc0    = n_epc;
    pulse_go();
    wait_halted(100);
    check_eq("br_nt_fetch", fetch_addr[base + 1], 32'd8);
    check_eq("br_nt_epc", 32'(n_epc - epc0), 32'd0);
    check_eq("br_nt_pc", pc, 32'd9);
`ifdef ILLEGAL_TRAP_EN
    check_eq("halt_not_illegal", 32'(illegal), 32'd0);
`endif

    // Asynchronous reset in the middle of a fetch
    clear_n = 1'b0;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    pulse_go();
    @(negedge clock);
    check_eq("mid_ram_read", 32'(dp.ram_read), 32'd1);
    #2 clear_n = 1'b0;
    #1;
    check_eq("mid_rst_ctl", 32'(ctl), 32'd0);
    check_eq("mid_rst_run", 32'(run), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
